// File: rtl/fft_unload_if.sv
// fft_unload_if
//   Bundles the FFT unload sequencer's control, mux-select and output stream
//   signals.
//   master : sequencer side (drives busy/done/sel and the m_* stream outputs)
//   slave  : environment side (drives start, mux_data, m_ready)
//   start/busy/done   control handshake
//   sel/mux_data      select to / data from the FFT output mux
//   m_data/m_valid/m_ready/m_last/m_index   output stream
interface fft_unload_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [10:0]           sel;
  logic [DATA_WIDTH-1:0] mux_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic [10:0]           m_index;

  modport master (
    input  start, mux_data, m_ready,
    output busy, done, sel, m_data, m_valid, m_last, m_index
  );

  modport slave (
    output start, mux_data, m_ready,
    input  busy, done, sel, m_data, m_valid, m_last, m_index
  );
endinterface

// File: rtl/fft_unload_sequencer.sv
// fft_unload_sequencer
//   Walks the 2048-entry FFT output mux, converts the mux's fixed read latency
//   into a valid/ready stream through a small first-word-fall-through FIFO.
//   Ports: clk, rst_n (async active-low), bus (fft_unload_if.master):
//     start in, busy/done out, sel out (registered mux select), mux_data in,
//     m_data/m_valid/m_last/m_index out, m_ready in.
//   Optional build macro FFT_UNLOAD_BITREV_EN: select is the 11-bit
//   bit-reversal of the issue counter; otherwise select equals the counter.
//
//   state | meaning
//   IDLE  | waiting for start (start-accept edge is the first issue)
//   RUN   | issuing selects while credits allow, until index 2047 issued
//   DRAIN | waiting for the last beat to leave the FIFO, then pulse done
module fft_unload_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int MUX_LATENCY = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input logic         clk,
  input logic         rst_n,
  fft_unload_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic [11:0]     cnt;
  logic            issue_v;
  logic [10:0]     issue_idx;
  logic [10:0]     sel_q;
  logic            busy_q;
  logic            done_q;
  logic [CW-1:0]   credit;
  logic [CW-1:0]   credit_nxt;
  logic            issue;
  logic            pop;

  logic [MUX_LATENCY-1:0] pipe_v;
  logic [10:0]            pipe_idx [MUX_LATENCY];

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [10:0]           mem_idx  [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           fifo_count;
  logic                  fifo_wr;

  function automatic logic [10:0] sel_map(input logic [10:0] idx);
`ifdef FFT_UNLOAD_BITREV_EN
    logic [10:0] r;
    for (int i = 0; i < 11; i++) r[i] = idx[10-i];
    return r;
`else
    return idx;
`endif
  endfunction

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_wr    = pipe_v[MUX_LATENCY-1];
  assign pop        = bus.m_valid && bus.m_ready;

  // A pop on this edge frees a credit in time for an issue on the same edge.
  always_comb begin
    issue = 1'b0;
    case (state)
      IDLE:    issue = bus.start;
      RUN:     issue = !cnt[11] && ((credit < CW'(FIFO_DEPTH)) || pop);
      default: issue = 1'b0;
    endcase
  end

  assign credit_nxt = credit + CW'(issue) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      issue_v   <= 1'b0;
      issue_idx <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      credit    <= '0;
    end else begin
      done_q  <= 1'b0;
      issue_v <= issue;
      credit  <= credit_nxt;
      if (issue) begin
        sel_q     <= sel_map(cnt[10:0]);
        issue_idx <= cnt[10:0];
        cnt       <= cnt + 12'd1;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (issue && cnt == 12'd2047) state <= DRAIN;
        end
        DRAIN: begin
          if (credit_nxt == '0) begin
            state  <= IDLE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            cnt    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid/index delay line matching the mux read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < MUX_LATENCY; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_v[0]   <= issue_v;
      pipe_idx[0] <= issue_idx;
      for (int i = 1; i < MUX_LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Storage is cleared on reset so the head reads as zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_idx[i]  <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (fifo_wr) begin
        mem_data[wr_ptr[AW-1:0]] <= bus.mux_data;
        mem_idx[wr_ptr[AW-1:0]]  <= pipe_idx[MUX_LATENCY-1];
        mem_last[wr_ptr[AW-1:0]] <= (pipe_idx[MUX_LATENCY-1] == 11'd2047);
        wr_ptr                   <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.m_valid = (wr_ptr != rd_ptr);
  assign bus.m_data  = mem_data[rd_ptr[AW-1:0]];
  assign bus.m_index = mem_idx[rd_ptr[AW-1:0]];
  assign bus.m_last  = bus.m_valid && mem_last[rd_ptr[AW-1:0]];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr && !pop && fifo_count == (AW+1)'(FIFO_DEPTH)));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    credit <= CW'(FIFO_DEPTH));
endmodule

// File: tb/tb_fft_unload_sequencer.sv
module tb_fft_unload_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_unload_if #(.DATA_WIDTH(8)) bus();

  fft_unload_sequencer #(
    .DATA_WIDTH(8), .MUX_LATENCY(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

`ifdef FFT_UNLOAD_BITREV_EN
  localparam logic [10:0] EXP_SEL3 = 11'd1536;
`else
  localparam logic [10:0] EXP_SEL3 = 11'd3;
`endif

  typedef struct packed {
    logic [7:0]  d;
    logic [10:0] idx;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mode     = 2;
  int pat      = 0;
  int beats    = 0;
  int last_cyc = -10;
  int done_cnt = 0;
  int done_cyc = -1;
  int max_credit = 0;
  bit mon_en   = 1'b0;

  function automatic logic [10:0] map_sel(input logic [10:0] a);
`ifdef FFT_UNLOAD_BITREV_EN
    logic [10:0] r;
    for (int i = 0; i < 11; i++) r[i] = a[10-i];
    return r;
`else
    return a;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mux model: registered sel -> data 3 cycles later, data = address[7:0].
  logic [10:0] mux_d1, mux_d2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_d1       <= '0;
      mux_d2       <= '0;
      bus.mux_data <= '0;
    end else begin
      mux_d1       <= bus.sel;
      mux_d2       <= mux_d1;
      bus.mux_data <= mux_d2[7:0];
    end
  end

  always @(posedge clk) cyc++;

  // Sink: 0 = always ready, 1 = pattern 1,0,0,1, other = held low.
  initial bus.m_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    case (mode)
      0: bus.m_ready = 1'b1;
      1: begin
        bus.m_ready = (pat % 4 == 0) || (pat % 4 == 3);
        pat++;
      end
      default: bus.m_ready = 1'b0;
    endcase
  end

  // Monitor: head of stream checked against the scoreboard every valid cycle,
  // so a stalled head must keep matching the same expected entry.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (int'(dut.credit) > max_credit) max_credit = int'(dut.credit);
      if (bus.m_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: index %0d data 0x%0h with empty scoreboard", bus.m_index, bus.m_data);
        end else begin
          check("beat_index", 32'(bus.m_index), 32'(exp_q[0].idx));
          check("beat_data",  32'(bus.m_data),  32'(exp_q[0].d));
          check("beat_last",  32'(bus.m_last),  32'(exp_q[0].last));
          if (bus.m_ready) begin
            if (exp_q[0].last) last_cyc = cyc;
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_frame();
    beat_t b;
    bus.start = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      b.idx  = 11'(i);
      b.d    = map_sel(11'(i)) & 11'h0FF;
      b.last = (i == 2047);
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic finish_frame(input int exp_done);
    int waited;
    waited = 0;
    while (done_cnt < exp_done && waited < 20000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("done_timeout", 32'(done_cnt >= exp_done), 32'd1);
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("done_after_last_beat", 32'(done_cyc - last_cyc), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("single_done", 32'(done_cnt), 32'(exp_done));
    check("done_low", 32'(bus.done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    32'(bus.busy),    32'd0);
    check({tag, "_done"},    32'(bus.done),    32'd0);
    check({tag, "_sel"},     32'(bus.sel),     32'd0);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_m_last"},  32'(bus.m_last),  32'd0);
    check({tag, "_m_index"}, 32'(bus.m_index), 32'd0);
    check({tag, "_m_data"},  32'(bus.m_data),  32'd0);
  endtask

  initial begin
    int k;
    int b0;
    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: sink always ready, first-valid latency.
    mode = 0;
    start_frame();
    k = 0;
    while (k < 20 && !bus.m_valid) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("first_valid_latency", 32'(k), 32'd4);
    check("busy_in_frame", 32'(bus.busy), 32'd1);
    finish_frame(1);

    // Frame 2: sink ready pattern 1,0,0,1.
    mode = 1;
    start_frame();
    finish_frame(2);

    // Frame 3: sink stalled 100 cycles, exactly four issues.
    mode = 2;
    start_frame();
    repeat (100) @(posedge clk);
    #1;
    check("stall_sel", 32'(bus.sel), 32'(EXP_SEL3));
    check("stall_valid", 32'(bus.m_valid), 32'd1);
    check("stall_index", 32'(bus.m_index), 32'd0);
    mode = 0;
    finish_frame(3);

    // Frame 4: start re-pulsed mid-frame is ignored.
    start_frame();
    repeat (500) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    finish_frame(4);
    repeat (30) @(posedge clk);
    #1;
    check("no_restart_done", 32'(done_cnt), 32'd4);
    check("no_restart_busy", 32'(bus.busy), 32'd0);
    check("no_restart_valid", 32'(bus.m_valid), 32'd0);

    // Frame 5: reset at beat 1000, then a clean frame.
    b0 = beats;
    start_frame();
    k = 0;
    while ((beats - b0) < 1000 && k < 5000) begin
      @(posedge clk);
      k++;
    end
    check("reach_beat_1000", 32'((beats - b0) >= 1000), 32'd1);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    start_frame();
    finish_frame(5);

    check("max_credit_le_4", 32'(max_credit <= 4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
